// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared core defines for the program-counter generator (widths, vectors, state encoding)
package pc_gen_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0080;
  typedef enum logic [1:0] {PC_BOOT, PC_RUN, PC_HALT} pc_state_e;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: program counter with fetch handshake, stall, trap/redirect vectoring, misalign halt and fetch counter
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int INSTR_BYTES = 4,
  parameter logic [DW-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [DW-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 fetch_ready,
  input  logic                 redirect_valid,
  input  logic [DW-1:0]        redirect_target,
  input  logic                 trap_valid,
  output logic [DW-1:0]        pc,
  output logic                 pc_valid,
  output logic                 misalign_err,
  output logic [DW-1:0]        misalign_addr,
  output logic [CNT_WIDTH-1:0] fetch_count
);
  localparam int AW = $clog2(INSTR_BYTES);
  if (INSTR_BYTES != 2 && INSTR_BYTES != 4) begin : g_bad_ib
    $fatal(1, "pc_gen: INSTR_BYTES must be 2 or 4");
  end
  if (RESET_VECTOR[AW-1:0] != '0 || TRAP_VECTOR[AW-1:0] != '0) begin : g_bad_vec
    $fatal(1, "pc_gen: reset/trap vectors must be aligned to INSTR_BYTES");
  end
  pc_state_e state, state_d;
  logic [DW-1:0] pc_d, addr_d;
  logic err_d, fire, misaligned;
  assign pc_valid = state == PC_RUN && !stall;
  assign fire = pc_valid && fetch_ready;
  assign misaligned = redirect_target[AW-1:0] != '0;
  always_comb begin
    pc_d = pc;
    state_d = state;
    err_d = misalign_err;
    addr_d = misalign_addr;
    if (state == PC_BOOT) begin
      state_d = PC_RUN;
    end else if (state == PC_RUN) begin
      if (trap_valid) begin
        pc_d = TRAP_VECTOR;
      end else if (redirect_valid && !misaligned) begin
        pc_d = redirect_target;
      end else if (redirect_valid) begin
        state_d = PC_HALT;
        err_d = 1'b1;
        addr_d = redirect_target;
      end else if (fire) begin
        pc_d = pc + DW'(INSTR_BYTES);
      end
    end else if (trap_valid) begin
      pc_d = TRAP_VECTOR;
      state_d = PC_RUN;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      state <= PC_BOOT;
      misalign_err <= 1'b0;
      misalign_addr <= '0;
      fetch_count <= '0;
    end else begin
      pc <= pc_d;
      state <= state_d;
      misalign_err <= err_d;
      misalign_addr <= addr_d;
      fetch_count <= fetch_count + CNT_WIDTH'(fire);
    end
  end
endmodule
